// File: rtl/mult_seq_nbits.sv
// Sequential shift-add multiplier: WIDTH-cycle signed/unsigned multiply with valid/ready handshakes.
// Define MULT_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_seq_nbits #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1),
  localparam int PW    = 2 * WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [PW-1:0]    s_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic             neg;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt, mplier_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PW-1:0]    prod_full, prod, result;
  logic             finish;

`ifdef MULT_SEQ_EARLY_EXIT_EN
  logic [WIDTH-1:0] b_rem;
  logic [WIDTH-1:0] b_rem_nxt;
`endif

  // Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
  // NOTE: every always_comb output gets a default assignment first so no latch can be inferred.
  always_comb begin
    a_mag = a_i;
    b_mag = b_i;
    if (signed_i && a_i[WIDTH-1]) a_mag = '0 - a_i;
    if (signed_i && b_i[WIDTH-1]) b_mag = '0 - b_i;
  end

  // One add-and-shift step of {carry, acc, mplier}.
  always_comb begin
    sum        = {1'b0, acc} + {1'b0, mcand & {WIDTH{mplier[0]}}};
    acc_nxt    = sum[WIDTH:1];
    mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
    cnt_nxt    = cnt - CNT_W'(1);
    prod_full  = {acc_nxt, mplier_nxt};
  end

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // With no multiplier bits left, the remaining steps only shift, so one barrel shift replaces them.
  always_comb begin
    b_rem_nxt = b_rem >> 1;
    finish    = (cnt == CNT_W'(1)) || (b_rem_nxt == '0);
    prod      = prod_full >> cnt_nxt;
  end
`else
  always_comb begin
    finish = (cnt == CNT_W'(1));
    prod   = prod_full;
  end
`endif

  // Negating zero yields zero, so a signed zero product never becomes -0.
  always_comb begin
    result = prod;
    if (neg) result = {PW{1'b0}} - prod;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      s_o     <= '0;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      b_rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            mcand   <= a_mag;
            mplier  <= b_mag;
            acc     <= '0;
            neg     <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            cnt     <= CNT_W'(WIDTH);
`ifdef MULT_SEQ_EARLY_EXIT_EN
            b_rem   <= b_mag;
`endif
            ready_o <= 1'b0;
            state   <= CALC;
          end
        end

        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt_nxt;
`ifdef MULT_SEQ_EARLY_EXIT_EN
          b_rem  <= b_rem_nxt;
`endif
          if (finish) begin
            s_o     <= result;
            valid_o <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
